// File: rtl/inst_div.sv
// inst_div: iterative RV32M divider (DIV/DIVU/REM/REMU) in the execute stage.
// Restoring shift-subtract resolving DIV_BITS_PER_CYCLE quotient bits per clock.
// Divide-by-zero and signed overflow resolve in one cycle without stalling.
// Optional feature macro: DIV_REM_FUSE_EN. When defined, a DIV/REM pair on the same
// operands (back to back) completes its second half in one cycle.
module inst_div #(
  parameter int unsigned DIV_BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        cpurst,
  input  logic        de2ex_inst_valid_ffout,
  input  logic        de2ex_MD_OP_ffout,
  input  logic [2:0]  de2ex_aluop_ffout,
  input  logic [31:0] de2ex_rd_oprand1_ffout,
  input  logic [31:0] de2ex_rd_oprand2_ffout,
  input  logic [4:0]  de2ex_rs1addr_ffout,
  input  logic [4:0]  de2ex_rs2addr_ffout,
  input  logic [4:0]  de2ex_wr_regindex_ffout,
  input  logic        de2ex_MD_OP,
  input  logic [2:0]  de2ex_aluop,
  input  logic [4:0]  de2ex_rs1addr,
  input  logic [4:0]  de2ex_rs2addr,
  output logic        div2mem_complete_ffout,
  output logic [31:0] div2mem_result_ffout,
  output logic        div_stall
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ITERS = XLEN / DIV_BITS_PER_CYCLE;
  localparam int unsigned CNT_W = 5;

  localparam logic [2:0] ALU_DIV  = 3'b100;
  localparam logic [2:0] ALU_DIVU = 3'b101;
  localparam logic [2:0] ALU_REM  = 3'b110;
  localparam logic [2:0] ALU_REMU = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [XLEN-1:0]    rem, rem_nxt;
  logic [XLEN-1:0]    quo, quo_nxt;
  logic [XLEN-1:0]    dvs, dvs_nxt;
  logic               q_neg, q_neg_nxt;
  logic               r_neg, r_neg_nxt;
  logic               rem_op, rem_op_nxt;
  logic               complete_nxt;
  logic [XLEN-1:0]    result_nxt;
  logic               stall_c;
  logic               fuse, fuse_nxt;
  logic [XLEN-1:0]    fuse_val, fuse_val_nxt;

  logic            div_go, is_signed, op1_neg, op2_neg, ovf;
  logic [XLEN-1:0] mag1, mag2, q_fix, r_fix;
  logic [XLEN:0]   part;
  logic            fuse_p;

  assign div_go = de2ex_inst_valid_ffout & de2ex_MD_OP_ffout &
                  ((de2ex_aluop_ffout == ALU_DIV)  | (de2ex_aluop_ffout == ALU_DIVU) |
                   (de2ex_aluop_ffout == ALU_REM)  | (de2ex_aluop_ffout == ALU_REMU));

  // Operand decode: signed ops (DIV/REM) have funct3[0]==0
  assign is_signed = ~de2ex_aluop_ffout[0];
  assign op1_neg   = is_signed & de2ex_rd_oprand1_ffout[31];
  assign op2_neg   = is_signed & de2ex_rd_oprand2_ffout[31];
  assign mag1      = op1_neg ? (~de2ex_rd_oprand1_ffout + 32'd1) : de2ex_rd_oprand1_ffout;
  assign mag2      = op2_neg ? (~de2ex_rd_oprand2_ffout + 32'd1) : de2ex_rd_oprand2_ffout;
  assign ovf       = is_signed & (de2ex_rd_oprand1_ffout == 32'h8000_0000) &
                     (de2ex_rd_oprand2_ffout == 32'hFFFF_FFFF);
  assign q_fix     = q_neg ? (~quo + 32'd1) : quo;
  assign r_fix     = r_neg ? (~rem + 32'd1) : rem;

`ifdef DIV_REM_FUSE_EN
  // Next instruction is the complementary op on the same, unclobbered sources
  assign fuse_p = de2ex_MD_OP & de2ex_aluop[2] &
                  (de2ex_aluop == (de2ex_aluop_ffout ^ 3'b010)) &
                  (de2ex_rs1addr == de2ex_rs1addr_ffout) &
                  (de2ex_rs2addr == de2ex_rs2addr_ffout) &
                  (de2ex_rs1addr_ffout != de2ex_wr_regindex_ffout) &
                  (de2ex_rs2addr_ffout != de2ex_wr_regindex_ffout);
`else
  logic unused_fuse_inputs;
  assign fuse_p = 1'b0;
  assign unused_fuse_inputs = ^{de2ex_MD_OP, de2ex_aluop, de2ex_rs1addr, de2ex_rs2addr,
                                de2ex_rs1addr_ffout, de2ex_rs2addr_ffout,
                                de2ex_wr_regindex_ffout};
`endif

  // Stall is suppressed while reset is held so all outputs read zero
  assign div_stall = stall_c & ~cpurst;

  // State and datapath registers
  always_ff @(posedge clk or posedge cpurst) begin
    if (cpurst) begin
      state                  <= IDLE;
      cnt                    <= '0;
      rem                    <= '0;
      quo                    <= '0;
      dvs                    <= '0;
      q_neg                  <= 1'b0;
      r_neg                  <= 1'b0;
      rem_op                 <= 1'b0;
      fuse                   <= 1'b0;
      fuse_val               <= '0;
      div2mem_complete_ffout <= 1'b0;
      div2mem_result_ffout   <= '0;
    end else begin
      state                  <= state_nxt;
      cnt                    <= cnt_nxt;
      rem                    <= rem_nxt;
      quo                    <= quo_nxt;
      dvs                    <= dvs_nxt;
      q_neg                  <= q_neg_nxt;
      r_neg                  <= r_neg_nxt;
      rem_op                 <= rem_op_nxt;
      fuse                   <= fuse_nxt;
      fuse_val               <= fuse_val_nxt;
      div2mem_complete_ffout <= complete_nxt;
      div2mem_result_ffout   <= result_nxt;
    end
  end

  // Next-state, datapath update and stall generation
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    rem_nxt      = rem;
    quo_nxt      = quo;
    dvs_nxt      = dvs;
    q_neg_nxt    = q_neg;
    r_neg_nxt    = r_neg;
    rem_op_nxt   = rem_op;
    fuse_nxt     = fuse;
    fuse_val_nxt = fuse_val;
    complete_nxt = 1'b0;
    result_nxt   = div2mem_result_ffout;
    stall_c      = 1'b0;
    part         = '0;

    unique case (state)
      IDLE: begin
        fuse_nxt = 1'b0;
        if (div_go) begin
          if (fuse) begin
            result_nxt   = fuse_val;
            complete_nxt = 1'b1;
          end else if (de2ex_rd_oprand2_ffout == '0) begin
            result_nxt   = de2ex_aluop_ffout[1] ? de2ex_rd_oprand1_ffout : 32'hFFFF_FFFF;
            complete_nxt = 1'b1;
          end else if (ovf) begin
            result_nxt   = de2ex_aluop_ffout[1] ? 32'h0000_0000 : 32'h8000_0000;
            complete_nxt = 1'b1;
          end else begin
            stall_c    = 1'b1;
            rem_nxt    = '0;
            quo_nxt    = mag1;
            dvs_nxt    = mag2;
            q_neg_nxt  = op1_neg ^ op2_neg;
            r_neg_nxt  = op1_neg;
            rem_op_nxt = de2ex_aluop_ffout[1];
            cnt_nxt    = '0;
            state_nxt  = CALC;
          end
        end
      end
      CALC: begin
        if (!div_go) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          stall_c = 1'b1;
          for (int i = 0; i < int'(DIV_BITS_PER_CYCLE); i++) begin
            part    = {rem_nxt, quo_nxt[XLEN-1]};
            quo_nxt = {quo_nxt[XLEN-2:0], 1'b0};
            if (part >= {1'b0, dvs}) begin
              part       = part - {1'b0, dvs};
              quo_nxt[0] = 1'b1;
            end
            rem_nxt = part[XLEN-1:0];
          end
          if (cnt == CNT_W'(ITERS - 1)) begin
            cnt_nxt   = '0;
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      DONE: begin
        result_nxt   = rem_op ? r_fix : q_fix;
        complete_nxt = 1'b1;
        state_nxt    = IDLE;
        if (fuse_p) begin
          fuse_nxt     = 1'b1;
          fuse_val_nxt = rem_op ? q_fix : r_fix;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
